// File: rtl/unified_mem_arbiter.sv
// Arbiter for a single-ported unified memory shared by the fetch port and the load/store port.
// Optional fetch anti-starvation guard: define UMA_STARVE_GUARD_EN.
module unified_mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_LAT      = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_mem
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  localparam logic       OWN_IF   = 1'b0;
  localparam logic       OWN_D    = 1'b1;
  localparam logic [1:0] LAT_INIT = 2'(MEM_LAT - 1);

  if (MEM_LAT < 1 || MEM_LAT > 4 || STARVE_LIMIT < 1) begin : g_cfg_err
    $error("unified_mem_arbiter: MEM_LAT must be 1..4 and STARVE_LIMIT >= 1");
  end

  state_t     state_r;
  logic       owner_r;
  logic [1:0] lat_cnt_r;
  logic       opp_s;
  logic       resp_s;
  logic       force_if_s;

`ifdef UMA_STARVE_GUARD_EN
  localparam int            SW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic [SW-1:0] starve_cnt_r;

  assign force_if_s = (starve_cnt_r == STARVE_MAX) & if_req;

  // Count fetch opportunities lost to the data port; saturates at the limit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      starve_cnt_r <= {SW{1'b0}};
    end else if (if_gnt) begin
      starve_cnt_r <= {SW{1'b0}};
    end else if (opp_s && if_req && (starve_cnt_r != STARVE_MAX)) begin
      starve_cnt_r <= starve_cnt_r + {{(SW-1){1'b0}}, 1'b1};
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end
`else
  assign force_if_s = 1'b0;
`endif

  // Grant opportunity, arbitration and response-cycle detection.
  always_comb begin
    opp_s  = 1'b0;
    resp_s = 1'b0;
    d_gnt  = 1'b0;
    if_gnt = 1'b0;
    if (rst) begin
      opp_s  = (state_r == IDLE) || (lat_cnt_r == 2'd0);
      resp_s = (state_r == WAIT) && (lat_cnt_r == 2'd0);
      d_gnt  = opp_s & d_req & ~force_if_s;
      if_gnt = opp_s & if_req & ~d_gnt;
    end else begin
      opp_s  = 1'b0;
      resp_s = 1'b0;
    end
  end

  // Memory issue side: drive the winner's payload, zero when nothing issues.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = 4'b0000;
    mem_addr  = {ADDR_W{1'b0}};
    mem_wdata = {DATA_W{1'b0}};
    if (d_gnt) begin
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_be    = d_be;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (if_gnt) begin
      mem_en    = 1'b1;
      mem_be    = 4'b1111;
      mem_addr  = if_addr;
    end else begin
      mem_en    = 1'b0;
    end
  end

  // Response routing to the owner and pipeline stall generation.
  always_comb begin
    if_rvalid = resp_s & (owner_r == OWN_IF);
    d_rvalid  = resp_s & (owner_r == OWN_D);
    if_rdata  = {DATA_W{1'b0}};
    d_rdata   = {DATA_W{1'b0}};
    stall_if  = 1'b0;
    stall_mem = 1'b0;
    if (rst) begin
      if_rdata  = if_rvalid ? mem_rdata : {DATA_W{1'b0}};
      d_rdata   = d_rvalid ? mem_rdata : {DATA_W{1'b0}};
      stall_if  = if_req & ~if_gnt;
      stall_mem = (d_req & ~d_gnt) |
                  ((owner_r == OWN_D) & (state_r == WAIT) & ~d_rvalid);
    end else begin
      stall_if  = 1'b0;
    end
  end

  // Transaction tracker: a grant always (re)arms the latency countdown.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r   <= IDLE;
      owner_r   <= OWN_IF;
      lat_cnt_r <= 2'd0;
    end else if (if_gnt || d_gnt) begin
      state_r   <= WAIT;
      owner_r   <= d_gnt ? OWN_D : OWN_IF;
      lat_cnt_r <= LAT_INIT;
    end else if (state_r == WAIT) begin
      if (lat_cnt_r != 2'd0) begin
        lat_cnt_r <= lat_cnt_r - 2'd1;
      end else begin
        state_r   <= IDLE;
      end
    end else begin
      state_r   <= IDLE;
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Randomized scoreboard bench for unified_mem_arbiter; model tracks response due-cycles directly.
module tb_unified_mem_arbiter;

  localparam int LAT   = 3;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [3:0]  d_be;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        mem_en, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        stall_if, stall_mem;

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] data;
    bit          we;
  } txn_t;

  txn_t        if_q[$];
  txn_t        d_q[$];
  int          n_pass  = 0;
  int          n_total = 0;
  int          cyc     = 0;
  int          resp_due = -1;   // cycle in which the outstanding response returns, -1 if none
  bit          owner_d  = 1'b0;
  logic [31:0] rd_data  = 32'h0;
  int          starve   = 0;
  bit          if_hold  = 1'b0;
  bit          d_hold   = 1'b0;
  bit          ovr_valid = 1'b0;
  logic [31:0] ovr_data  = 32'h0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // One clock cycle: drive inputs after the edge, compare at the falling edge, advance the model.
  task automatic run_cycle(input int p_if, input int p_d, input bit rst_v);
    bit          opp, force_if, ig, dg;
    logic [31:0] dat;
    @(posedge clk);
    #1;
    cyc++;
    rst = rst_v;
    if (!rst_v) begin
      resp_due = -1;
      starve   = 0;
      if_q.delete();
      d_q.delete();
    end
    if (!if_hold && ($urandom_range(99) < p_if)) begin
      if_hold = 1'b1;
      if_addr = $urandom;
    end
    if (!d_hold && ($urandom_range(99) < p_d)) begin
      d_hold  = 1'b1;
      d_we    = 1'($urandom_range(1));
      d_be    = 4'($urandom);
      d_addr  = $urandom;
      d_wdata = $urandom;
    end
    if_req    = if_hold;
    d_req     = d_hold;
    mem_rdata = (resp_due == cyc) ? rd_data : $urandom;

    @(negedge clk);
    if (!rst_v) begin
      check("rst_ctl", {if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we, mem_be, stall_if, stall_mem}, 64'h0);
      check("rst_if_rdata", if_rdata, 64'h0);
      check("rst_d_rdata", d_rdata, 64'h0);
      check("rst_mem_addr", mem_addr, 64'h0);
      check("rst_mem_wdata", mem_wdata, 64'h0);
      return;
    end
    opp      = (resp_due < 0) || (resp_due == cyc);
`ifdef UMA_STARVE_GUARD_EN
    force_if = (starve == LIMIT) && if_req;
`else
    force_if = 1'b0;
`endif
    dg = opp && d_req && !force_if;
    ig = opp && if_req && !dg;
    check("if_gnt", if_gnt, ig);
    check("d_gnt", d_gnt, dg);
    check("mem_en", mem_en, ig || dg);
    check("mem_we", mem_we, dg && d_we);
    check("mem_be", mem_be, dg ? d_be : (ig ? 4'hF : 4'h0));
    check("mem_addr", mem_addr, dg ? d_addr : (ig ? if_addr : 32'h0));
    check("mem_wdata", mem_wdata, dg ? d_wdata : 32'h0);
    check("stall_if", stall_if, if_req && !ig);
    check("stall_mem", stall_mem, (d_req && !dg) || (owner_d && resp_due > cyc));

    if (opp && if_req && !ig && starve < LIMIT) starve++;
    if (ig) starve = 0;
    if (ig || dg) begin
      dat       = ovr_valid ? ovr_data : $urandom;
      rd_data   = dat;
      resp_due  = cyc + LAT;
      owner_d   = dg;
      if (dg) begin
        d_q.push_back('{due: cyc + LAT, data: dat, we: d_we});
        d_hold = 1'b0;
      end else begin
        if_q.push_back('{due: cyc + LAT, data: dat, we: 1'b0});
        if_hold = 1'b0;
      end
    end else if (resp_due == cyc) begin
      resp_due = -1;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((if_hold || d_hold || resp_due >= 0) && n < 40) begin
      run_cycle(0, 0, 1'b1);
      n++;
    end
    check("drain_bound", n < 40, 1'b1);
  endtask

  // Response monitor: pops the scoreboard whenever a port presents rvalid.
  always @(negedge clk) begin
    txn_t e;
    if (if_rvalid) begin
      if (if_q.size() == 0) check("if_rvalid_unexpected", 1'b1, 1'b0);
      else begin
        e = if_q.pop_front();
        check("if_resp_cycle", cyc, e.due);
        check("if_rdata", if_rdata, e.data);
      end
    end else begin
      check("if_rdata_idle", if_rdata, 32'h0);
      if (if_q.size() > 0 && if_q[0].due <= cyc) begin
        check("if_rvalid_missing", 1'b0, 1'b1);
        void'(if_q.pop_front());
      end
    end
    if (d_rvalid) begin
      if (d_q.size() == 0) check("d_rvalid_unexpected", 1'b1, 1'b0);
      else begin
        e = d_q.pop_front();
        check("d_resp_cycle", cyc, e.due);
        if (!e.we) check("d_rdata", d_rdata, e.data);
      end
    end else begin
      check("d_rdata_idle", d_rdata, 32'h0);
      if (d_q.size() > 0 && d_q[0].due <= cyc) begin
        check("d_rvalid_missing", 1'b0, 1'b1);
        void'(d_q.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b0; if_req = 1'b0; if_addr = 32'h0; d_req = 1'b0; d_we = 1'b0;
    d_be = 4'h0; d_addr = 32'h0; d_wdata = 32'h0; mem_rdata = 32'h0;

    // Reset with both requesters active; the load wins in the first cycle out of reset.
    if_hold = 1'b1; if_addr = 32'h40;
    d_hold = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h200; d_wdata = 32'h0;
    repeat (2) run_cycle(0, 0, 1'b0);
    run_cycle(0, 0, 1'b1);
    drain();

    // Single fetch with a known instruction word.
    if_hold = 1'b1; if_addr = 32'h10; ovr_valid = 1'b1; ovr_data = 32'h00A00093;
    run_cycle(0, 0, 1'b1);
    ovr_valid = 1'b0;
    drain();

    // Contention: load beats fetch, fetch follows at the response cycle.
    if_hold = 1'b1; if_addr = 32'h20;
    d_hold = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h100; d_wdata = 32'h0;
    drain();

    // Partial store.
    d_hold = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h180; d_wdata = 32'hDEADBEEF;
    drain();

    // Reset one cycle after a fetch issues: its response must never appear.
    if_hold = 1'b1; if_addr = 32'h30;
    run_cycle(0, 0, 1'b1);
    run_cycle(0, 0, 1'b0);
    repeat (4) run_cycle(0, 0, 1'b1);
    if_hold = 1'b1; if_addr = 32'h34;
    drain();

    // Both ports requesting continuously.
    repeat (40) run_cycle(100, 100, 1'b1);
    drain();

    // Random traffic with occasional resets.
    for (int i = 0; i < 2000; i++) begin
      run_cycle(60, 50, ($urandom_range(199) != 0));
    end
    drain();
    repeat (2) run_cycle(0, 0, 1'b1);
    check("if_q_empty", if_q.size(), 0);
    check("d_q_empty", d_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
